icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipelined datapath fetch port and the memory arbiter/cache-control instruction port.
- Returns hits combinationally in the same cycle.
- On a miss, runs a one-word block fill from memory, then serves the hit.
- One 32-bit word per block; no write path, since the instruction side is never written.

---
 rtl/icache_direct.sv | 144 ++++++++++++++
 tb/tb_icache_direct.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// ============================================================================
// icache_direct
//   Direct-mapped, read-only instruction cache, one 32-bit word per line.
//   Hits return combinationally in the requesting cycle. A miss latches the
//   word address and runs a single-word fill from memory (IDLE -> FETCH ->
//   IDLE). After the fill the cache re-evaluates the current request.
//
// Parameters:
//   SETS      number of lines (power of two, 2..256)
//
// Ports:
//   CLK, nRST         clock / asynchronous active-low reset
//   imemREN, imemaddr fetch request and byte address from the datapath
//   ihit, imemload    hit strobe and instruction word (0 when no hit)
//   flush             single-cycle pulse, invalidates every line
//   iREN, iaddr       memory read request and word address (FETCH only)
//   iwait, iload      memory busy flag and read data
//   hit_count,        (ICACHE_STATS_EN only) wrapping 32-bit counters of
//   miss_count         hit cycles and IDLE->FETCH transitions
//
// Optional feature macro: ICACHE_STATS_EN
// ============================================================================
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
`ifdef ICACHE_STATS_EN
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`else
    input  logic [31:0] iload
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fill_q, fill_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAGW-1:0]    tag_q  [SETS];
    logic [31:0]        data_q [SETS];

    logic [IDXW-1:0]    req_idx, fill_idx;
    logic [TAGW-1:0]    req_tag, fill_tag;
    logic               hit, fill_done, start_fill;
    logic               unused_addr_lsb;

    assign req_idx  = imemaddr[IDXW+1:2];
    assign req_tag  = imemaddr[31:IDXW+2];
    assign fill_idx = fill_q[IDXW+1:2];
    assign fill_tag = fill_q[31:IDXW+2];

    // Byte offset carries no information for a word-per-line cache.
    assign unused_addr_lsb = ^imemaddr[1:0];

    // A flush cycle never reports a hit: the line is about to be invalidated.
    assign hit = imemREN && (state_q == IDLE) && valid_q[req_idx] &&
                 (tag_q[req_idx] == req_tag) && !flush;

    assign ihit      = hit;
    assign imemload  = hit ? data_q[req_idx] : 32'h0;
    assign fill_done = (state_q == FETCH) && !iwait;
    assign start_fill = (state_q == IDLE) && imemREN && !hit && !flush;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        iREN    = 1'b0;
        iaddr   = 32'h0;
        case (state_q)
            IDLE: begin
                if (start_fill) begin
                    state_d = FETCH;
                    fill_d  = {imemaddr[31:2], 2'b00};
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = fill_q;
                // The fill always completes to the latched address, even if
                // the datapath has redirected or dropped imemREN meanwhile.
                if (!iwait) begin
                    state_d           = IDLE;
                    valid_d[fill_idx] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Applied last so a flush on the fill edge leaves the new line invalid.
        if (flush) valid_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fill_q  <= 32'h0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit)        hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (start_fill) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    int unsigned exp_hits = 0, exp_miss = 0;
`endif

    icache_direct #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait),
`ifdef ICACHE_STATS_EN
        .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
`else
        .iload(iload)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } hit_t;

    hit_t        hq[$];   // expected hits (address, data)
    logic [31:0] fq[$];   // expected fill-cycle memory addresses

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a hit or a fill.
    always @(negedge CLK) begin
        if (nRST) begin
            if (ihit) begin
                if (hq.size() == 0) chk("unexpected_hit", imemaddr, 32'hFFFF_FFFF);
                else begin
                    hit_t e;
                    e = hq.pop_front();
                    chk("hit_addr", imemaddr, e.a);
                    chk("hit_data", imemload, e.d);
                end
            end
            if (iREN && !iwait) begin
                if (fq.size() == 0) chk("unexpected_fill", iaddr, 32'hFFFF_FFFF);
                else                chk("fill_addr", iaddr, fq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Request expected to hit this cycle.
    task automatic req_hit(input logic [31:0] a, input logic [31:0] d);
        hit_t e;
        e.a = a; e.d = d;
        hq.push_back(e);
        imemREN = 1'b1; imemaddr = a; flush = 1'b0;
        #1;
        chk("hit_no_iren", {31'b0, iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
        exp_hits++;
`endif
        tick();
    endtask

    // Request expected to miss; runs the fill with `waits` busy cycles.
    // Returns in the first IDLE cycle after the fill.
    task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int waits,
                             input logic [31:0] redir, input logic fl_at_fill);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; flush = 1'b0;
        fq.push_back(a);
        #1;
        chk("miss_ihit", {31'b0, ihit}, 32'd0);
`ifdef ICACHE_STATS_EN
        exp_miss++;
`endif
        tick();
        for (int i = 0; i < waits; i++) begin
            chk("wait_iren", {31'b0, iREN}, 32'd1);
            chk("wait_iaddr", iaddr, a);
            chk("wait_ihit", {31'b0, ihit}, 32'd0);
            if (i == 0 && redir != 32'h0) imemaddr = redir;
            tick();
        end
        iwait = 1'b0; iload = d; flush = fl_at_fill;
        #1;
        chk("fill_iren", {31'b0, iREN}, 32'd1);
        tick();
        iwait = 1'b1; iload = 32'h0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0;
        iwait = 1'b1; iload = 32'h0;
        #12;
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_iren", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        imemREN = 1'b0;
        tick();
        nRST = 1'b1;
        tick();

        // Cold miss (2 wait cycles) then warm hits.
        miss_fill(32'h40, 32'h2001_0005, 2, 32'h0, 1'b0);
        req_hit(32'h40, 32'h2001_0005);
        req_hit(32'h43, 32'h2001_0005);   // byte offset ignored

        // Conflict eviction at index 0.
        miss_fill(32'h80, 32'h1111_2222, 1, 32'h0, 1'b0);
        req_hit(32'h80, 32'h1111_2222);
        miss_fill(32'h40, 32'h2001_0005, 0, 32'h0, 1'b0);
        req_hit(32'h40, 32'h2001_0005);

        // Redirect mid-fill: 0x100 completes, then 0x200 misses.
        miss_fill(32'h100, 32'hAAAA_0100, 3, 32'h200, 1'b0);
        miss_fill(32'h200, 32'hBBBB_0200, 1, 32'h0, 1'b0);
        req_hit(32'h200, 32'hBBBB_0200);

        // Flush in IDLE.
        miss_fill(32'h48, 32'hCCCC_0048, 1, 32'h0, 1'b0);
        req_hit(32'h48, 32'hCCCC_0048);
        imemREN = 1'b1; imemaddr = 32'h48; flush = 1'b1;
        #1;
        chk("flush_ihit", {31'b0, ihit}, 32'd0);
        tick();
        flush = 1'b0;
        miss_fill(32'h48, 32'hCCCC_1048, 0, 32'h0, 1'b0);
        req_hit(32'h48, 32'hCCCC_1048);
        miss_fill(32'h200, 32'hBBBB_1200, 0, 32'h0, 1'b0);
        req_hit(32'h200, 32'hBBBB_1200);

        // Flush on the fill edge: the filled line stays invalid.
        miss_fill(32'h40, 32'h2001_0005, 1, 32'h0, 1'b1);
        miss_fill(32'h40, 32'h2001_0006, 0, 32'h0, 1'b0);
        req_hit(32'h40, 32'h2001_0006);

`ifdef ICACHE_STATS_EN
        chk("stat_hits", hit_count, exp_hits);
        chk("stat_miss", miss_count, exp_miss);
`endif

        // Async reset mid-FETCH.
        imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
        tick();
        chk("pre_rst_iren", {31'b0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("async_rst_iren", {31'b0, iREN}, 32'd0);
        chk("async_rst_iaddr", iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
        chk("rst_stat_hits", hit_count, 32'h0);
        chk("rst_stat_miss", miss_count, 32'h0);
        exp_hits = 0; exp_miss = 0;
`endif
        tick();
        nRST = 1'b1;
        miss_fill(32'h40, 32'h2001_0007, 1, 32'h0, 1'b0);
        req_hit(32'h40, 32'h2001_0007);

        imemREN = 1'b0;
        tick();
        tick();
        chk("hq_drained", hq.size(), 32'd0);
        chk("fq_drained", fq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
